// File: rtl/mask_prng.sv
// mask_prng: fresh-mask generator built around a 32-bit maximal-length LFSR
// (x^32+x^22+x^2+x+1). A seed is loaded through a handshake. The LFSR is then
// warmed up, and WIDTH bits are handed out per accepted transfer. After
// RESEED_INTERVAL words the generator freezes until it is given a new seed.
module mask_prng #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned WARMUP_CYCLES   = 8,
  parameter int unsigned RESEED_INTERVAL = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [31:0]      seed_data,
  output logic             seed_ready,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd,
  output logic             reseed_req
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [7:0]  WARM_INIT     = 8'(WARMUP_CYCLES);
  localparam logic [15:0] INTERVAL_INIT = 16'(RESEED_INTERVAL);
  localparam bit          WARMUP_NONE   = (WARMUP_CYCLES == 32'd0);
  localparam bit          NEVER_EXPIRE  = (RESEED_INTERVAL == 32'd0);

  // Single LFSR step: shift left and insert the feedback bit at the bottom.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  // One advance consumes WIDTH steps, so every delivered word uses fresh bits.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < int'(WIDTH); i++) begin
      t = lfsr_step(t);
    end
    return t;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] s_q, s_d;
  logic [7:0]  warm_cnt_q, warm_cnt_d;
  logic [15:0] words_left_q, words_left_d;
  logic        seed_ready_q, seed_ready_d;
  logic        rnd_valid_q, rnd_valid_d;
  logic        reseed_req_q, reseed_req_d;

  logic        seed_acc_s;
  logic        hs_s;
  logic [31:0] seed_fixed_s;

  assign seed_ready = seed_ready_q;
  assign rnd_valid  = rnd_valid_q;
  assign reseed_req = reseed_req_q;
  assign rnd        = s_q[WIDTH-1:0];

  // Next-state logic: seed load has priority over any advance, including a
  // handshake in the same cycle (that word still counts as consumed).
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    warm_cnt_d   = warm_cnt_q;
    words_left_d = words_left_q;
    seed_acc_s   = seed_valid & seed_ready_q;
    hs_s         = rnd_valid_q & rnd_ready;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    seed_fixed_s = (seed_data == 32'h0000_0000) ? 32'h0000_0001 : seed_data;

    if (seed_acc_s) begin
      s_d = seed_fixed_s;
      if (WARMUP_NONE) begin
        state_d      = ST_RUN;
        warm_cnt_d   = 8'd0;
        words_left_d = INTERVAL_INIT;
      end else begin
        state_d      = ST_WARMUP;
        warm_cnt_d   = WARM_INIT;
        words_left_d = words_left_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WARMUP: begin
          s_d = lfsr_advance(s_q);
          if (warm_cnt_q <= 8'd1) begin
            state_d      = ST_RUN;
            warm_cnt_d   = 8'd0;
            words_left_d = INTERVAL_INIT;
          end else begin
            state_d    = ST_WARMUP;
            warm_cnt_d = warm_cnt_q - 8'd1;
          end
        end
        ST_RUN: begin
          if (hs_s) begin
            s_d = lfsr_advance(s_q);
            if (NEVER_EXPIRE) begin
              words_left_d = words_left_q;
            end else if (words_left_q <= 16'd1) begin
              state_d      = ST_EXPIRED;
              words_left_d = 16'd0;
            end else begin
              words_left_d = words_left_q - 16'd1;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d      = ST_IDLE;
          s_d          = 32'h0000_0000;
          warm_cnt_d   = 8'd0;
          words_left_d = 16'd0;
        end
      endcase
    end
  end

  // Output decode from the next state so the flags are registered alongside it.
  always_comb begin
    seed_ready_d = 1'b1;
    rnd_valid_d  = 1'b0;
    reseed_req_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        seed_ready_d = 1'b1;
      end
      ST_WARMUP: begin
        seed_ready_d = 1'b0;
      end
      ST_RUN: begin
        rnd_valid_d = 1'b1;
      end
      ST_EXPIRED: begin
        reseed_req_d = 1'b1;
      end
      default: begin
        seed_ready_d = 1'b1;
        rnd_valid_d  = 1'b0;
        reseed_req_d = 1'b0;
      end
    endcase
  end

  // State, LFSR, counters and output flags; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_q          <= 32'h0000_0000;
      warm_cnt_q   <= 8'd0;
      words_left_q <= 16'd0;
      seed_ready_q <= 1'b1;
      rnd_valid_q  <= 1'b0;
      reseed_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      warm_cnt_q   <= warm_cnt_d;
      words_left_q <= words_left_d;
      seed_ready_q <= seed_ready_d;
      rnd_valid_q  <= rnd_valid_d;
      reseed_req_q <= reseed_req_d;
    end
  end

endmodule
